// File: rtl/rx_slot_ctrl_pkg.sv
// Shared definitions for the RX slot-ring controller: arm FSM encoding and slot geometry.
package rx_slot_ctrl_pkg;

    localparam int SLOT_ADDR_BITS = 11;
    localparam int SLOT_BYTES     = 1 << SLOT_ADDR_BITS;

    typedef enum logic [1:0] {
        ARM_DISABLED = 2'd0,
        ARM_ARMED    = 2'd1,
        ARM_HOLD     = 2'd2,
        ARM_FULL     = 2'd3
    } arm_state_t;

endpackage

// File: rtl/rx_irq_coalesce.sv
// Coalesced RX interrupt: fires on a pending-count threshold or when a partial batch ages out.
module rx_irq_coalesce #(
    parameter int SLOT_BITS = 2,
    parameter int TIMER_W   = 16
) (
    input  logic                 pci_clk,
    input  logic                 sys_rst_n,
    input  logic [SLOT_BITS:0]   pending,
    input  logic [SLOT_BITS:0]   irq_threshold,
    input  logic [TIMER_W-1:0]   irq_timeout,
    input  logic                 irq_ack,
    output logic                 irq
);

    localparam logic [SLOT_BITS:0] THR_MIN  = 1;
    localparam logic [TIMER_W-1:0] TMR_STEP = 1;

    logic [TIMER_W-1:0] timer;
    logic [SLOT_BITS:0] thr_eff;
    logic               set_cond;

    // A threshold of zero would fire with an empty ring, so it is treated as one.
    assign thr_eff  = (irq_threshold == '0) ? THR_MIN : irq_threshold;
    assign set_cond = (pending >= thr_eff) ||
                      ((pending != '0) && (irq_timeout != '0) && (timer == irq_timeout));

    always_ff @(posedge pci_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            irq   <= 1'b0;
            timer <= '0;
        end else begin
            if (irq_ack) begin
                irq <= 1'b0;
            end else if (set_cond) begin
                irq <= 1'b1;
            end

            if ((pending == '0) || irq_ack) begin
                timer <= '0;
            end else if (!irq && (timer != '1)) begin
                timer <= timer + TMR_STEP;
            end
        end
    end

endmodule

// File: rtl/rx_slot_ctrl.sv
// RX frame-buffer slot ring: write/read slot indices, receiver arm FSM and interrupt coalescing.
//
// state    | meaning
// DISABLED | host has reception off; receiver is never armed
// ARMED    | current write slot is free, rx_empty high
// HOLD     | a frame just landed; rx_empty held low while hold_cnt drains
// FULL     | every slot holds a frame; waiting for the host to release one
module rx_slot_ctrl
    import rx_slot_ctrl_pkg::*;
#(
    parameter int SLOT_BITS = 2,
    parameter int HOLD_CYC  = 8,
    parameter int TIMER_W   = 16
) (
    input  logic                 pci_clk,
    input  logic                 sys_rst_n,
    input  logic                 rx_enable,
    input  logic                 rx_complete,
    output logic                 rx_empty,
    output logic [SLOT_BITS-1:0] rx_slot_sel,
    output logic [SLOT_BITS-1:0] host_slot_sel,
    input  logic                 host_release,
    output logic [SLOT_BITS:0]   pending,
    input  logic [SLOT_BITS:0]   irq_threshold,
    input  logic [TIMER_W-1:0]   irq_timeout,
    input  logic                 irq_ack,
    output logic                 irq,
    output logic [31:0]          frame_count,
    output logic                 overflow_err,
    output logic                 release_err
);

    localparam int                   HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
    localparam logic [HOLD_W-1:0]    HOLD_STEP = 1;
    localparam logic [SLOT_BITS:0]   FULL_CNT  = (SLOT_BITS + 1)'(1 << SLOT_BITS);
    localparam logic [SLOT_BITS:0]   PEND_STEP = 1;
    localparam logic [SLOT_BITS-1:0] IDX_STEP  = 1;

    arm_state_t          state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                acc_rx;
    logic                acc_rel;
    logic [SLOT_BITS:0]  pending_nxt;
    logic                full_nxt;

    // Both pulses are judged on the pre-cycle count, so a full ring rejects a frame
    // even when the host frees a slot in the same cycle.
    assign acc_rx   = rx_complete && (pending != FULL_CNT);
    assign acc_rel  = host_release && (pending != '0);
    assign full_nxt = (pending_nxt == FULL_CNT);

    always_comb begin
        pending_nxt = pending;
        if (acc_rx && !acc_rel) begin
            pending_nxt = pending + PEND_STEP;
        end else if (!acc_rx && acc_rel) begin
            pending_nxt = pending - PEND_STEP;
        end
    end

    always_ff @(posedge pci_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_slot_sel   <= '0;
            host_slot_sel <= '0;
            pending       <= '0;
            frame_count   <= '0;
            overflow_err  <= 1'b0;
            release_err   <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (acc_rx) begin
                rx_slot_sel <= rx_slot_sel + IDX_STEP;
                frame_count <= frame_count + 32'd1;
            end
            if (acc_rel) begin
                host_slot_sel <= host_slot_sel + IDX_STEP;
            end
            if (rx_complete && !acc_rx) begin
                overflow_err <= 1'b1;
            end
            if (host_release && !acc_rel) begin
                release_err <= 1'b1;
            end
        end
    end

    // rx_empty only rises on entry from HOLD or FULL; out of DISABLED it waits one
    // extra cycle so the receiver sees a settled enable before arming.
    always_ff @(posedge pci_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ARM_DISABLED;
            hold_cnt <= '0;
            rx_empty <= 1'b0;
        end else begin
            rx_empty <= 1'b0;
            case (state)
                ARM_DISABLED: begin
                    if (rx_enable) begin
                        state <= full_nxt ? ARM_FULL : ARM_ARMED;
                    end
                end
                ARM_ARMED: begin
                    if (acc_rx) begin
                        state    <= ARM_HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end else if (!rx_enable) begin
                        state <= ARM_DISABLED;
                    end else begin
                        rx_empty <= 1'b1;
                    end
                end
                ARM_HOLD: begin
                    if (acc_rx) begin
                        hold_cnt <= HOLD_LOAD;
                    end else if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HOLD_STEP;
                    end else if (!rx_enable) begin
                        state <= ARM_DISABLED;
                    end else if (full_nxt) begin
                        state <= ARM_FULL;
                    end else begin
                        state    <= ARM_ARMED;
                        rx_empty <= 1'b1;
                    end
                end
                ARM_FULL: begin
                    if (!rx_enable) begin
                        state <= ARM_DISABLED;
                    end else if (!full_nxt) begin
                        state    <= ARM_ARMED;
                        rx_empty <= 1'b1;
                    end
                end
                default: state <= ARM_DISABLED;
            endcase
        end
    end

    rx_irq_coalesce #(
        .SLOT_BITS (SLOT_BITS),
        .TIMER_W   (TIMER_W)
    ) u_irq (
        .pci_clk       (pci_clk),
        .sys_rst_n     (sys_rst_n),
        .pending       (pending),
        .irq_threshold (irq_threshold),
        .irq_timeout   (irq_timeout),
        .irq_ack       (irq_ack),
        .irq           (irq)
    );

endmodule

// File: tb/tb_rx_slot_ctrl.sv
// Bench for rx_slot_ctrl: cycle model of the ring/arm/irq rules plus directed scenarios.
module tb_rx_slot_ctrl;

    localparam int SLOT_BITS = 2;
    localparam int HOLD_CYC  = 8;
    localparam int TIMER_W   = 16;
    localparam int N         = 1 << SLOT_BITS;
    localparam int TMR_MAX   = (1 << TIMER_W) - 1;

    logic                 pci_clk = 1'b0;
    logic                 sys_rst_n = 1'b0;
    logic                 rx_enable = 1'b0;
    logic                 rx_complete = 1'b0;
    logic                 host_release = 1'b0;
    logic                 irq_ack = 1'b0;
    logic [SLOT_BITS:0]   irq_threshold = 3'd4;
    logic [TIMER_W-1:0]   irq_timeout = '0;
    logic                 rx_empty;
    logic [SLOT_BITS-1:0] rx_slot_sel;
    logic [SLOT_BITS-1:0] host_slot_sel;
    logic [SLOT_BITS:0]   pending;
    logic                 irq;
    logic [31:0]          frame_count;
    logic                 overflow_err;
    logic                 release_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 pci_clk = ~pci_clk;

    rx_slot_ctrl #(
        .SLOT_BITS (SLOT_BITS),
        .HOLD_CYC  (HOLD_CYC),
        .TIMER_W   (TIMER_W)
    ) dut (
        .pci_clk       (pci_clk),
        .sys_rst_n     (sys_rst_n),
        .rx_enable     (rx_enable),
        .rx_complete   (rx_complete),
        .rx_empty      (rx_empty),
        .rx_slot_sel   (rx_slot_sel),
        .host_slot_sel (host_slot_sel),
        .host_release  (host_release),
        .pending       (pending),
        .irq_threshold (irq_threshold),
        .irq_timeout   (irq_timeout),
        .irq_ack       (irq_ack),
        .irq           (irq),
        .frame_count   (frame_count),
        .overflow_err  (overflow_err),
        .release_err   (release_err)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: ring as plain counters; rx_empty derived from "enabled for two samples,
    // room after this cycle, and HOLD_CYC edges since the last accepted frame".
    int     m_pending, m_w, m_r, m_fc, m_age, m_thr;
    bit     m_ovf, m_rerr, m_irq, m_empty, m_en_prev;
    bit     a_rx, a_rel, m_set;
    longint edge_no, hold_until;

    always @(posedge pci_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_pending = 0; m_w = 0; m_r = 0; m_fc = 0; m_age = 0;
            m_ovf = 0; m_rerr = 0; m_irq = 0; m_empty = 0; m_en_prev = 0;
            hold_until = 0;
        end else begin
            edge_no++;
            a_rx  = rx_complete && (m_pending < N);
            a_rel = host_release && (m_pending > 0);
            if (rx_complete && !a_rx) m_ovf = 1;
            if (host_release && !a_rel) m_rerr = 1;

            m_thr = (irq_threshold == 0) ? 1 : int'(irq_threshold);
            m_set = (m_pending >= m_thr) ||
                    (m_pending > 0 && irq_timeout != 0 && m_age == int'(irq_timeout));
            if (m_pending == 0 || irq_ack) m_age = 0;
            else if (!m_irq && m_age < TMR_MAX) m_age = m_age + 1;
            m_irq = irq_ack ? 1'b0 : (m_irq | m_set);

            if (a_rx) begin
                m_w = (m_w + 1) % N;
                m_fc = m_fc + 1;
                hold_until = edge_no + HOLD_CYC;
            end
            if (a_rel) m_r = (m_r + 1) % N;
            m_pending = m_pending + int'(a_rx) - int'(a_rel);

            m_empty = rx_enable && m_en_prev && (m_pending < N) && (edge_no >= hold_until);
            m_en_prev = rx_enable;
        end
    end

    always @(negedge pci_clk) begin
        chk("model rx_empty", rx_empty, m_empty);
        chk("model rx_slot_sel", rx_slot_sel, m_w);
        chk("model host_slot_sel", host_slot_sel, m_r);
        chk("model pending", pending, m_pending);
        chk("model irq", irq, m_irq);
        chk("model frame_count", frame_count, m_fc);
        chk("model overflow_err", overflow_err, m_ovf);
        chk("model release_err", release_err, m_rerr);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge pci_clk);
    endtask

    task automatic pulse_rx();
        rx_complete = 1'b1; tick(); rx_complete = 1'b0;
    endtask

    task automatic pulse_rel();
        host_release = 1'b1; tick(); host_release = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int j;
        tick(2);
        sys_rst_n = 1'b1;
        chk("reset rx_empty", rx_empty, 0);
        chk("reset pending", pending, 0);
        chk("reset irq", irq, 0);
        chk("reset frame_count", frame_count, 0);

        // enable -> rx_empty two cycles later
        tick(); rx_enable = 1'b1;
        tick(); chk("enable+1 rx_empty", rx_empty, 0);
        tick(); chk("enable+2 rx_empty", rx_empty, 1);
        chk("enable rx_slot_sel", rx_slot_sel, 0);
        chk("enable pending", pending, 0);

        // hold window after a frame
        pulse_rx();
        chk("hold rx_slot_sel", rx_slot_sel, 1);
        for (int i = 1; i <= 9; i++) begin
            chk("hold rx_empty", rx_empty, 32'(i == 9));
            if (i < 9) tick();
        end
        tick(11);

        // fill the ring, overflow, then free one slot
        repeat (3) begin
            pulse_rx(); tick(19);
        end
        chk("full pending", pending, 4);
        chk("full rx_empty", rx_empty, 0);
        chk("full rx_slot_sel", rx_slot_sel, 0);
        pulse_rx();
        chk("overflow flag", overflow_err, 1);
        chk("overflow pending", pending, 4);
        chk("overflow frame_count", frame_count, 4);
        tick(2);
        pulse_rel();
        chk("release host_slot_sel", host_slot_sel, 1);
        chk("release pending", pending, 3);
        chk("release rx_empty", rx_empty, 1);

        // simultaneous frame and release with pending = 2
        pulse_rel(); tick(2);
        chk("pre-both pending", pending, 2);
        rx_complete = 1'b1; host_release = 1'b1; tick();
        rx_complete = 1'b0; host_release = 1'b0;
        chk("both pending", pending, 2);
        chk("both rx_slot_sel", rx_slot_sel, 1);
        chk("both host_slot_sel", host_slot_sel, 3);
        pulse_rel(); pulse_rel();
        chk("drain host_slot_sel wrap", host_slot_sel, 1);
        pulse_rel();
        chk("release_err flag", release_err, 1);
        chk("release_err host_slot_sel", host_slot_sel, 1);
        chk("release_err rx_slot_sel", rx_slot_sel, 1);
        chk("release_err pending", pending, 0);

        // interrupt: timeout, ack, threshold
        irq_threshold = 3'd3; irq_timeout = 16'd100;
        pulse_ack();
        chk("ack irq", irq, 0);
        tick(10);
        pulse_rx();
        j = 0;
        while (irq !== 1'b1 && j < 200) begin
            tick(); j++;
        end
        chk("timeout latency", j, (j >= 100 && j <= 102) ? j : 101);
        pulse_ack();
        chk("ack clears irq", irq, 0);
        pulse_rx(); tick(3); pulse_rx();
        chk("threshold pending", pending, 3);
        chk("threshold irq before", irq, 0);
        tick();
        chk("threshold irq after", irq, 1);

        // reset with a frame in flight
        rx_complete = 1'b1;
        #2 sys_rst_n = 1'b0;
        #1;
        chk("midreset pending", pending, 0);
        chk("midreset rx_slot_sel", rx_slot_sel, 0);
        chk("midreset host_slot_sel", host_slot_sel, 0);
        chk("midreset irq", irq, 0);
        chk("midreset frame_count", frame_count, 0);
        chk("midreset overflow_err", overflow_err, 0);
        chk("midreset release_err", release_err, 0);
        chk("midreset rx_empty", rx_empty, 0);
        rx_complete = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        tick(2);
        chk("post-reset rx_empty", rx_empty, 1);

        // wrap-around with frame/release pairs
        for (int p = 0; p < 10; p++) begin
            pulse_rx(); tick(11); pulse_rel(); tick();
            if (p == 3) begin
                chk("wrap rx_slot_sel", rx_slot_sel, 0);
                chk("wrap host_slot_sel", host_slot_sel, 0);
            end
        end
        chk("pairs frame_count", frame_count, 10);
        chk("pairs pending", pending, 0);
        chk("pairs rx_slot_sel", rx_slot_sel, 2);
        chk("pairs host_slot_sel", host_slot_sel, 2);
        chk("pairs overflow_err", overflow_err, 0);
        chk("pairs release_err", release_err, 0);

        rx_enable = 1'b0;
        tick();
        chk("disable rx_empty", rx_empty, 0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
